keccak_padder_multi: RTL and testbench
======================================

// Module: keccak_padder_multi
// PURPOSE
//  Parametrised multi-rate input padder for the keccak core. Packs IN_W-bit message words into a rate-sized block.
//  Applies Keccak (0x01) or SHA3 (0x06) domain padding with the final 0x80 bit.
//  Hands each block to the permutation stage through an out_ready/f_ack handshake.
//  Unlike the fixed 32-bit/576-bit padder, it supports run-time rate selection, multi-block messages and
//  back-to-back messages without an intervening reset.
// PARAMETERS
//  IN_W      32    input word width; 32 or 64
//  MAX_RATE  1152  buffer/out width in bits (largest rate, SHA3-224)
//  BN_W      $clog2(IN_W/8)  byte_num width (derived)
// PORTS
//  clk       in   1         clock, rising edge
//  reset_n   in   1         asynchronous, active-low reset
//  mode      in   2         00:r=1152 01:r=1088 10:r=832 11:r=576
//  domain    in   1         0: Keccak pad byte 0x01; 1: SHA3 pad byte 0x06
//  in        in   IN_W      message word; first byte at MSBs
//  in_ready  in   1         in valid this cycle
//  is_last   in   1         in is the last word of the message
//  byte_num  in   BN_W      valid bytes in the last word (0..IN_W/8-1), MSB-aligned
//  buffer_full out 1        1: input not accepted this cycle
//  out       out  MAX_RATE  block; word k at out[MAX_RATE-1-k*IN_W -: IN_W]; bits below rate are 0
//  out_ready out  1         block valid
//  out_last  out  1         qualifies out_ready: block is the final block of the message
//  f_ack     in   1         consumer took the block
// BEHAVIOUR
//  Reset (async, reset_n=0): state=ACCUM, cnt=0, out=0, buffer_full=0, out_ready=0, out_last=0.
//  R = rate/IN_W words per block (IN_W=32: 36/34/26/18; IN_W=64: 18/17/13/9). cnt width = $clog2(MAX_RATE/IN_W+1).
//  mode and domain are latched on the first accepted word of each message; changes mid-message are ignored.
//  Word acceptance: in_ready=1 and buffer_full=0. Inputs are ignored otherwise.
//  ACCUM:
//   - Non-last word: written at word position cnt; cnt++. If cnt reaches R: go to FULL, out_last=0.
//   - Last word: byte_num MSB bytes kept; domain byte at byte position byte_num; lower bytes 0.
//     If cnt==R-1, the LSB byte is ORed with 0x80 (0x81/0x86 when coincident) and the state goes to FULL, out_last=1.
//     Otherwise cnt++ and the state goes to PAD.
//   - A message always ends within the current block, because the last word always has at least one free byte.
//  PAD:
//   - buffer_full=1; one word appended per clock.
//   - Word R-1 = 0x00..0080; all earlier pad words = 0. After word R-1: FULL, out_last=1.
//  FULL:
//   - buffer_full=1, out_ready=1, out stable.
//   - On f_ack: out=0, cnt=0, out_ready=0, go to ACCUM.
//   - If out_last was set, the next accepted word starts a new message (mode/domain relatched).
//  f_ack outside FULL is ignored. in_ready coinciding with f_ack in FULL is ignored; the word must be re-presented.
//  Latency: non-final block ready 1 clk after its R-th word; final block ready (R-1-cnt_at_last) clks after the last word.
//  Reset asserted mid-operation: immediate return to reset values; the partial block is discarded.
// STRUCTURE
//  keccak_pkg: rate constants per mode, PAD_KECCAK=8'h01, PAD_SHA3=8'h06, PAD_END=8'h80, state enum {ACCUM,PAD,FULL}.
//  Sub-module keccak_pad_word (combinational): in, byte_num, pad_byte, final_word -> padded IN_W word.
//  Top level: FSM, cnt, and a word-indexed write into out (no shift register, so variable rate is handled directly).
// TESTING
//  1. IN_W=32, mode=01, domain=1: "Hell","o, w","orld", then "!   " with byte_num=1, is_last=1.
//     -> word3=0x21060000, words4..32=0, word33=0x00000080, 30 PAD clks, then out_ready=1, out_last=1.
//  2. mode=11: 17 words, then is_last with byte_num=3, in="dog " at cnt=17.
//     -> word17=0x646F6786, no PAD, out_ready on the next clk, out_last=1.
//  3. mode=11: 18 full words, then is_last with byte_num=0.
//     -> block1 out_ready=1, out_last=0, input ignored until f_ack.
//     -> block2 word0=0x06000000, word17=0x00000080, out_last=1.
//  4. domain=0, mode=10, is_last with byte_num=0 at word0.
//     -> word0=0x01000000, word25=0x00000080, out[319:0]=0.
//  5. reset_n=0 during PAD -> out=0, out_ready=0, buffer_full=0 without waiting for clk.
//     Also: mode toggled mid-message is ignored; after f_ack of a final block, a new message with mode=00 uses R=36.
//  6. IN_W=64, mode=01: 16 words, then is_last with byte_num=7.
//     -> word16 LSB byte=0x86, out_ready next clk.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared definitions for the multi-rate keccak input padder:
// padder FSM states, domain/terminal pad bytes and the mode -> rate map.
package keccak_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    PAD,
    FULL
  } state_e;

  localparam logic [7:0] PAD_KECCAK = 8'h01;
  localparam logic [7:0] PAD_SHA3   = 8'h06;
  localparam logic [7:0] PAD_END    = 8'h80;

  // Rate in bits for each mode code.
  function automatic int unsigned rate_bits(input logic [1:0] mode);
    case (mode)
      2'b00:   return 1152;
      2'b01:   return 1088;
      2'b10:   return 832;
      default: return 576;
    endcase
  endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// Combinational padding of the last message word.
// Ports:
//   word_i     : message word, first byte at MSBs
//   byte_num_i : number of valid MSB-aligned bytes in word_i
//   pad_byte_i : domain pad byte placed right after the valid bytes
//   final_i    : word is the last of the block; OR 0x80 into the LSB byte
//   word_o     : padded word
module keccak_pad_word
  import keccak_pkg::*;
#(
  parameter int IN_W = 32,
  parameter int BN_W = $clog2(IN_W / 8)
) (
  input  logic [IN_W-1:0] word_i,
  input  logic [BN_W-1:0] byte_num_i,
  input  logic [7:0]      pad_byte_i,
  input  logic            final_i,
  output logic [IN_W-1:0] word_o
);

  localparam int unsigned NB = IN_W / 8;

  always_comb begin
    word_o = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (b < 32'(byte_num_i)) begin
        word_o[IN_W-1-8*b -: 8] = word_i[IN_W-1-8*b -: 8];
      end else if (b == 32'(byte_num_i)) begin
        word_o[IN_W-1-8*b -: 8] = pad_byte_i;
      end
    end
    // Domain byte and terminal bit may share the LSB byte (0x81 / 0x86).
    if (final_i) begin
      word_o[7:0] = word_o[7:0] | PAD_END;
    end
  end

endmodule

// File: rtl/keccak_padder_multi.sv
// Multi-rate keccak input padder. Packs IN_W-bit words into a rate-sized
// block, applies Keccak/SHA3 domain padding plus the final 0x80 bit and
// hands each block over through out_ready/f_ack.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   mode                : rate select 00:1152 01:1088 10:832 11:576
//   domain              : 0 Keccak pad byte 0x01, 1 SHA3 pad byte 0x06
//   in, in_ready        : message word (first byte at MSBs) and its valid
//   is_last, byte_num   : last word of message, valid bytes in it
//   buffer_full         : input not accepted this cycle
//   out, out_ready      : block (word k at out[MAX_RATE-1-k*IN_W -: IN_W])
//   out_last            : block ends the message
//   f_ack               : consumer took the block
module keccak_padder_multi
  import keccak_pkg::*;
#(
  parameter int IN_W     = 32,
  parameter int MAX_RATE = 1152,
  parameter int BN_W     = $clog2(IN_W / 8)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          mode,
  input  logic                domain,
  input  logic [IN_W-1:0]     in,
  input  logic                in_ready,
  input  logic                is_last,
  input  logic [BN_W-1:0]     byte_num,
  output logic                buffer_full,
  output logic [MAX_RATE-1:0] out,
  output logic                out_ready,
  output logic                out_last,
  input  logic                f_ack
);

  localparam int unsigned NW    = MAX_RATE / IN_W;
  localparam int unsigned CNT_W = $clog2(NW + 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [MAX_RATE-1:0] out_q;
  logic                buffer_full_q;
  logic                out_ready_q;
  logic                out_last_q;
  logic                new_msg_q;
  logic [1:0]          mode_q;
  logic                domain_q;

  logic                starting;
  logic [1:0]          cur_mode;
  logic                cur_domain;
  logic [CNT_W-1:0]    r_words;
  logic                at_last;
  logic [7:0]          pad_byte;
  logic [IN_W-1:0]     padded;

  // On the first word of a message the live mode/domain apply; afterwards
  // the latched copies are used so mid-message changes have no effect.
  always_comb begin
    starting   = (state_q == ACCUM) && new_msg_q;
    cur_mode   = starting ? mode : mode_q;
    cur_domain = starting ? domain : domain_q;
    r_words    = CNT_W'(rate_bits(cur_mode) / 32'(IN_W));
    at_last    = (cnt_q == r_words - 1'b1);
    pad_byte   = cur_domain ? PAD_SHA3 : PAD_KECCAK;
  end

  keccak_pad_word #(
    .IN_W (IN_W),
    .BN_W (BN_W)
  ) u_pad_word (
    .word_i     (in),
    .byte_num_i (byte_num),
    .pad_byte_i (pad_byte),
    .final_i    (at_last),
    .word_o     (padded)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ACCUM;
      cnt_q         <= '0;
      out_q         <= '0;
      buffer_full_q <= 1'b0;
      out_ready_q   <= 1'b0;
      out_last_q    <= 1'b0;
      new_msg_q     <= 1'b1;
      mode_q        <= '0;
      domain_q      <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_ready && !buffer_full_q) begin
            if (new_msg_q) begin
              mode_q   <= mode;
              domain_q <= domain;
            end
            new_msg_q <= is_last;
            if (is_last) begin
              out_q[MAX_RATE-1-int'(cnt_q)*IN_W -: IN_W] <= padded;
              buffer_full_q <= 1'b1;
              if (at_last) begin
                state_q     <= FULL;
                out_ready_q <= 1'b1;
                out_last_q  <= 1'b1;
              end else begin
                cnt_q   <= cnt_q + 1'b1;
                state_q <= PAD;
              end
            end else begin
              out_q[MAX_RATE-1-int'(cnt_q)*IN_W -: IN_W] <= in;
              cnt_q <= cnt_q + 1'b1;
              if (at_last) begin
                state_q       <= FULL;
                buffer_full_q <= 1'b1;
                out_ready_q   <= 1'b1;
                out_last_q    <= 1'b0;
              end
            end
          end
        end
        PAD: begin
          out_q[MAX_RATE-1-int'(cnt_q)*IN_W -: IN_W] <=
            at_last ? IN_W'(PAD_END) : '0;
          if (at_last) begin
            state_q     <= FULL;
            out_ready_q <= 1'b1;
            out_last_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FULL: begin
          if (f_ack) begin
            out_q         <= '0;
            cnt_q         <= '0;
            out_ready_q   <= 1'b0;
            out_last_q    <= 1'b0;
            buffer_full_q <= 1'b0;
            state_q       <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign buffer_full = buffer_full_q;
  assign out         = out_q;
  assign out_ready   = out_ready_q;
  assign out_last    = out_last_q;

endmodule

// File: tb/tb_keccak_padder_multi.sv
// Directed bench for keccak_padder_multi (IN_W=32 and IN_W=64 instances).
module tb_keccak_padder_multi;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          domain = 1'b0;
  logic          f_ack = 1'b0;

  logic [31:0]   in32 = '0;
  logic          in_ready32 = 1'b0;
  logic          is_last32 = 1'b0;
  logic [1:0]    bn32 = '0;
  logic          bf32;
  logic [1151:0] out32;
  logic          or32;
  logic          ol32;

  logic [63:0]   in64 = '0;
  logic          in_ready64 = 1'b0;
  logic          is_last64 = 1'b0;
  logic [2:0]    bn64 = '0;
  logic          bf64;
  logic [1151:0] out64;
  logic          or64;
  logic          ol64;
  logic          f_ack64 = 1'b0;

  int total = 0;
  int bad = 0;
  int n;
  logic [1151:0] exp_blk;

  always #5 clk = ~clk;

  keccak_padder_multi #(.IN_W(32), .MAX_RATE(1152)) dut32 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .domain(domain),
    .in(in32), .in_ready(in_ready32), .is_last(is_last32), .byte_num(bn32),
    .buffer_full(bf32), .out(out32), .out_ready(or32), .out_last(ol32),
    .f_ack(f_ack)
  );

  keccak_padder_multi #(.IN_W(64), .MAX_RATE(1152)) dut64 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .domain(domain),
    .in(in64), .in_ready(in_ready64), .is_last(is_last64), .byte_num(bn64),
    .buffer_full(bf64), .out(out64), .out_ready(or64), .out_last(ol64),
    .f_ack(f_ack64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_w(input int k, input logic [31:0] v);
    exp_blk[1151-k*32 -: 32] = v;
  endtask

  task automatic chk_block(input string tag);
    for (int k = 0; k < 36; k++) begin
      chk($sformatf("%s_w%0d", tag, k), {32'h0, out32[1151-k*32 -: 32]},
          {32'h0, exp_blk[1151-k*32 -: 32]});
    end
  endtask

  task automatic send(input logic [31:0] w, input logic last, input logic [1:0] bn);
    in32 = w; in_ready32 = 1'b1; is_last32 = last; bn32 = bn;
    @(posedge clk); #1;
    in_ready32 = 1'b0; is_last32 = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (or32 !== 1'b1 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic ack;
    f_ack = 1'b1;
    @(posedge clk); #1;
    f_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out_ready", or32, 0);
    chk("rst_buffer_full", bf32, 0);
    chk("rst_out_last", ol32, 0);
    chk("rst_out_zero", |out32, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: mode 01, SHA3, "Hello, world!"
    mode = 2'b01; domain = 1'b1;
    send(32'h48656C6C, 0, 0);
    send(32'h6F2C2077, 0, 0);
    send(32'h6F726C64, 0, 0);
    send(32'h21202020, 1, 1);
    chk("t1_pad_busy", bf32, 1);
    chk("t1_pad_not_ready", or32, 0);
    wait_ready(n);
    chk("t1_pad_clks", n, 30);
    chk("t1_out_last", ol32, 1);
    exp_blk = '0;
    set_w(0, 32'h48656C6C); set_w(1, 32'h6F2C2077); set_w(2, 32'h6F726C64);
    set_w(3, 32'h21060000); set_w(33, 32'h00000080);
    chk_block("t1");
    ack;
    chk("t1_ack_ready", or32, 0);
    chk("t1_ack_bf", bf32, 0);
    chk("t1_ack_out_zero", |out32, 0);

    // 2: mode 11, last word coincides with block end
    mode = 2'b11; domain = 1'b1;
    exp_blk = '0;
    for (int k = 0; k < 17; k++) begin
      send(32'h10000000 + 32'(k), 0, 0);
      set_w(k, 32'h10000000 + 32'(k));
    end
    send(32'h646F6720, 1, 3);
    chk("t2_ready_next_clk", or32, 1);
    chk("t2_out_last", ol32, 1);
    set_w(17, 32'h646F6786);
    chk_block("t2");
    ack;

    // 3: two-block message, input blocked while FULL, mid-message mode/domain change ignored
    mode = 2'b11; domain = 1'b1;
    exp_blk = '0;
    for (int k = 0; k < 18; k++) begin
      send(32'hA0000000 + 32'(k), 0, 0);
      set_w(k, 32'hA0000000 + 32'(k));
    end
    chk("t3_blk1_ready", or32, 1);
    chk("t3_blk1_not_last", ol32, 0);
    chk_block("t3a");
    in32 = 32'hDEADBEEF; in_ready32 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t3_full_bf", bf32, 1);
    chk("t3_full_w0_held", out32[1151 -: 32], 32'hA0000000);
    is_last32 = 1'b1; f_ack = 1'b1;
    @(posedge clk); #1;
    f_ack = 1'b0; in_ready32 = 1'b0; is_last32 = 1'b0;
    chk("t3_ack_with_in_ignored", |out32, 0);
    chk("t3_ack_bf", bf32, 0);
    mode = 2'b00; domain = 1'b0;
    send(32'hFFFFFFFF, 1, 0);
    wait_ready(n);
    chk("t3_pad_clks", n, 17);
    chk("t3_out_last", ol32, 1);
    exp_blk = '0;
    set_w(0, 32'h06000000); set_w(17, 32'h00000080);
    chk_block("t3b");
    ack;

    // 4: Keccak domain, mode 10, empty last word
    mode = 2'b10; domain = 1'b0;
    send(32'h12345678, 1, 0);
    wait_ready(n);
    chk("t4_pad_clks", n, 25);
    exp_blk = '0;
    set_w(0, 32'h01000000); set_w(25, 32'h00000080);
    chk_block("t4");
    chk("t4_below_rate", |out32[319:0], 0);
    ack;

    // New message after a final block picks up mode 00 (R=36)
    mode = 2'b00; domain = 1'b1;
    send(32'hAABBCCDD, 1, 2);
    wait_ready(n);
    chk("t5_m0_pad_clks", n, 35);
    exp_blk = '0;
    set_w(0, 32'hAABB0600); set_w(35, 32'h00000080);
    chk_block("t5m0");
    ack;

    // 5: asynchronous reset during PAD
    send(32'h11223344, 1, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_in_pad", bf32, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rst_out_zero", |out32, 0);
    chk("t5_rst_ready", or32, 0);
    chk("t5_rst_bf", bf32, 0);
    chk("t5_rst_last", ol32, 0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_after_rst_bf", bf32, 0);

    // 6: IN_W=64, mode 01, last word fills all but one byte at block end
    mode = 2'b01; domain = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in64 = 64'h1111000000000000 + 64'(k); in_ready64 = 1'b1; is_last64 = 1'b0;
      @(posedge clk); #1;
    end
    in64 = 64'h0102030405060708; is_last64 = 1'b1; bn64 = 3'd7;
    @(posedge clk); #1;
    in_ready64 = 1'b0; is_last64 = 1'b0;
    chk("t6_ready_next_clk", or64, 1);
    chk("t6_out_last", ol64, 1);
    chk("t6_w0", out64[1151 -: 64], 64'h1111000000000000);
    chk("t6_w15", out64[1151-15*64 -: 64], 64'h111100000000000F);
    chk("t6_w16", out64[127:64], 64'h0102030405060786);
    chk("t6_w17_zero", out64[63:0], 64'h0);
    f_ack64 = 1'b1;
    @(posedge clk); #1;
    f_ack64 = 1'b0;
    chk("t6_ack_ready", or64, 0);
    chk("t6_ack_out_zero", |out64, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
